lsu_bus_master: RTL and testbench
=================================

Name: lsu_bus_master

Overview:
- Initiator side of the data-memory path: accepts one load/store at a time from the execute stage.
- Drives a word-addressed valid/ready memory bus with byte strobes, and waits for each bus response.
- Returns aligned, sign/zero-extended load data to the pipeline.
- Accesses that cross a 32-bit word boundary are split into two bus beats and merged.

Parameters:
- ADDR_W, 32, byte-address width on both interfaces.
- ALLOW_MISALIGNED, 1. When 0, any misaligned access is rejected with resp_err and no bus traffic.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  pipeline request valid.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse; no backpressure.
- resp_rdata  out  32  extended load result; 0 for stores and errors.
- resp_err  out  1  illegal funct3 or rejected misalignment.
- mem_req_valid  out  1  bus request valid.
- mem_req_ready  in  1  bus accepts the request.
- mem_req_addr  out  ADDR_W  word-aligned address, bits [1:0] always 0.
- mem_req_wen  out  1  write enable.
- mem_req_wstrb  out  4  byte strobes; 0000 on reads.
- mem_req_wdata  out  32  lane-positioned write data.
- mem_rsp_valid  in  1  read data ready or write acknowledged.
- mem_rsp_rdata  in  32  read word.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE and all outputs are 0, except req_ready, which is 1.
  - Capture registers are cleared.
  - Reset mid-transaction abandons it; a later mem_rsp_valid is ignored in IDLE.
- Access size and offset:
  - size = 1/2/4 bytes from funct3[1:0]; off = addr[1:0].
  - split = (off + size > 4).
  - Legal codes: loads 000, 001, 010, 100, 101; stores 000, 001, 010.
- Address and strobe generation:
  - Byte mask m8 = ((1<<size)-1) << off, 8 bits.
  - Beat0: addr = {addr[ADDR_W-1:2], 2'b00}, wstrb = m8[3:0].
  - Beat1: addr = beat0 + 4, wrapping modulo 2^ADDR_W; wstrb = m8[7:4].
  - Store data: w64 = {32'b0, wdata} << (8*off). Beat0 sends w64[31:0]; beat1 sends w64[63:32].
- States:
  - IDLE: req_ready=1. On req_valid, capture the request.
    - Illegal code, or misaligned with ALLOW_MISALIGNED=0 -> ERR.
    - Otherwise -> REQ0.
  - REQ0: mem_req_valid=1 with beat0 fields held stable until mem_req_ready; then -> WAIT0.
  - WAIT0: on mem_rsp_valid, latch lo = mem_rsp_rdata; -> REQ1 if split, else RESP.
  - REQ1 / WAIT1: same as REQ0 / WAIT0 with beat1; latch hi; -> RESP.
  - RESP: resp_valid=1 for one cycle, resp_err=0; -> IDLE.
  - ERR: resp_valid=1, resp_err=1, resp_rdata=0; -> IDLE.
- Load merge: r64 = {hi, lo} >> (8*off).
  - Byte: sign- or zero-extend r64[7:0].
  - Half: sign- or zero-extend r64[15:0].
  - Word: r64[31:0].
  - hi is treated as 0 when not split.
- Stores still wait for mem_rsp_valid acks (ordering guarantee). Store resp_rdata = 0.
- Latency, from the accept cycle, with zero-wait memory (ready=1, response one cycle after handshake):
  - Aligned access: resp_valid 3 cycles later.
  - Split access: 5 cycles later.
  - Illegal/rejected access: 1 cycle later.
- Bus rules:
  - mem_rsp_valid is sampled only in WAIT0/WAIT1 and is ignored elsewhere.
  - Memory must not respond in the same cycle as the request handshake.
- The next request cannot be accepted in the same cycle as resp_valid; req_ready rises the following cycle.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP, ERR}.
  - A size-decode function.
- One combinational sub-module, lsu_align:
  - Store side: funct3, off, wdata -> m8, w64.
  - Load side: funct3, off, lo, hi -> extended rdata.
  - The FSM stays in lsu_bus_master.

Test Plan:
Memory preloaded: 0x100 = 0x44332211, 0x104 = 0x88776655.
1. LW 0x100 -> one beat at addr 0x100, wen=0; resp_rdata=0x44332211 at accept+3.
2. LB 0x107 -> resp_rdata=0xFFFFFF88. LBU 0x107 -> 0x00000088. LHU 0x106 -> 0x00008877.
3. LW 0x102 -> beats at 0x100 then 0x104; resp_rdata=0x66554433 at accept+5.
4. SH 0x103, wdata 0x0000BEEF:
   - beat0: 0x100, wstrb 1000, wdata 0xEF000000.
   - beat1: 0x104, wstrb 0001, wdata 0x000000BE.
   - Readback via LW 0x100 = 0xEF332211.
5. Load funct3=011 and store funct3=100 -> no mem_req_valid; resp_valid with resp_err=1 at accept+1.
6. mem_req_ready held low 5 cycles, with fields checked stable; then rst_n pulsed low in WAIT0:
   - All outputs go to 0 immediately and req_ready=1.
   - A stray mem_rsp_valid is ignored.
   - A fresh LW completes correctly.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit bus master.
// Holds the RV32I width codes, the FSM state encoding and small
// decode helpers used by both the FSM and the alignment datapath.
package lsu_pkg;

  // RV32I load/store width codes (funct3)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    WAIT0,
    REQ1,
    WAIT1,
    RESP,
    ERR
  } lsu_state_t;

  // Access size in bytes (1, 2 or 4) from the low two funct3 bits.
  function automatic logic [2:0] size_decode(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Stores only have signed-form codes; loads also accept BU/HU.
  function automatic logic is_legal(input logic write, input logic [2:0] funct3);
    if (write)
      return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else
      return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
             (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment for the load/store unit.
// Ports:
//   funct3 - RV32I width code of the captured access
//   off    - byte offset within the first word (addr[1:0])
//   wdata  - right-aligned store data
//   lo, hi - read words from beat0 / beat1 (hi must be 0 if not split)
//   m8     - 8-bit byte mask spanning both beats
//   w64    - store data shifted into lane position across both beats
//   rdata  - merged, sign/zero-extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  output logic [7:0]  m8,
  output logic [63:0] w64,
  output logic [31:0] rdata
);

  logic [7:0]  base_mask;
  logic [31:0] r32;

  // Byte mask and store lanes are the right-aligned forms shifted by the
  // byte offset; anything spilling past bit 31 belongs to the second beat.
  // Loads undo the same shift on the concatenated {hi, lo} pair.
  always_comb begin
    base_mask = 8'h0F;
    case (size_decode(funct3[1:0]))
      3'd1:    base_mask = 8'h01;
      3'd2:    base_mask = 8'h03;
      default: base_mask = 8'h0F;
    endcase
    m8  = base_mask << off;
    w64 = {32'b0, wdata} << {off, 3'b000};
    r32 = 32'({hi, lo} >> {off, 3'b000});
    case (funct3)
      F3_B:    rdata = {{24{r32[7]}}, r32[7:0]};
      F3_H:    rdata = {{16{r32[15]}}, r32[15:0]};
      F3_W:    rdata = r32;
      F3_BU:   rdata = {24'b0, r32[7:0]};
      F3_HU:   rdata = {16'b0, r32[15:0]};
      default: rdata = 32'b0;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store unit bus master: takes one load/store at a time from the
// execute stage, issues one or two word beats on a valid/ready memory bus
// (two when the access crosses a word boundary), waits for each response
// and returns aligned, extended load data.
// Ports:
//   clk, rst_n              - clock, async active-low reset
//   req_*                   - pipeline request (valid/ready, write, funct3, addr, wdata)
//   resp_*                  - one-cycle response pulse with data and error flag
//   mem_req_*               - bus request (valid/ready, word addr, wen, strobes, data)
//   mem_rsp_valid/rdata     - bus response (read data or write ack)
module lsu_bus_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [3:0]        mem_req_wstrb,
  output logic [31:0]       mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_rdata
);

  lsu_state_t state, state_next;

  logic              write_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       lo_q;
  logic [31:0]       hi_q;
  logic              split_q;

  logic [2:0]        req_size;
  logic [1:0]        req_off;
  logic              req_split;
  logic              req_misaligned;
  logic              req_bad;
  logic              accept;

  logic [ADDR_W-1:0] beat0_addr;
  logic [ADDR_W-1:0] beat1_addr;
  logic [7:0]        m8;
  logic [63:0]       w64;
  logic [31:0]       load_rdata;

  // Request classification, evaluated on the live request in IDLE.
  // Misaligned means the offset is not a multiple of the size.
  assign req_size       = size_decode(req_funct3[1:0]);
  assign req_off        = req_addr[1:0];
  assign req_split      = ({2'b00, req_off} + {1'b0, req_size}) > 4'd4;
  assign req_misaligned = (req_off & 2'(req_size - 3'd1)) != 2'b00;
  assign req_bad        = !is_legal(req_write, req_funct3) ||
                          (!ALLOW_MISALIGNED && req_misaligned);
  assign accept         = (state == IDLE) && req_valid;

  // Second beat wraps naturally at the top of the address space.
  assign beat0_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign beat1_addr = beat0_addr + ADDR_W'(4);

  lsu_align u_align (
    .funct3 (funct3_q),
    .off    (addr_q[1:0]),
    .wdata  (wdata_q),
    .lo     (lo_q),
    .hi     (split_q ? hi_q : 32'b0),
    .m8     (m8),
    .w64    (w64),
    .rdata  (load_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Capture registers: request fields on accept, read words in the wait
  // states. lo/hi are cleared at accept so a non-split access merges with 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q  <= 1'b0;
      funct3_q <= 3'b0;
      addr_q   <= '0;
      wdata_q  <= 32'b0;
      lo_q     <= 32'b0;
      hi_q     <= 32'b0;
      split_q  <= 1'b0;
    end else begin
      if (accept) begin
        write_q  <= req_write;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        split_q  <= req_split;
        lo_q     <= 32'b0;
        hi_q     <= 32'b0;
      end
      if (state == WAIT0 && mem_rsp_valid) lo_q <= mem_rsp_rdata;
      if (state == WAIT1 && mem_rsp_valid) hi_q <= mem_rsp_rdata;
    end
  end

  // Next-state and output decode. Every output is a pure function of the
  // state and capture registers, so reset forces them all to their idle
  // values immediately.
  always_comb begin
    state_next    = state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_wen   = 1'b0;
    mem_req_wstrb = 4'b0;
    mem_req_wdata = 32'b0;
    resp_valid    = 1'b0;
    resp_err      = 1'b0;
    resp_rdata    = 32'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_bad ? ERR : REQ0;
      end
      REQ0: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = beat0_addr;
        mem_req_wen   = write_q;
        mem_req_wstrb = write_q ? m8[3:0] : 4'b0;
        mem_req_wdata = write_q ? w64[31:0] : 32'b0;
        if (mem_req_ready) state_next = WAIT0;
      end
      WAIT0: begin
        if (mem_rsp_valid) state_next = split_q ? REQ1 : RESP;
      end
      REQ1: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = beat1_addr;
        mem_req_wen   = write_q;
        mem_req_wstrb = write_q ? m8[7:4] : 4'b0;
        mem_req_wdata = write_q ? w64[63:32] : 32'b0;
        if (mem_req_ready) state_next = WAIT1;
      end
      WAIT1: begin
        if (mem_rsp_valid) state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = write_q ? 32'b0 : load_rdata;
        state_next = IDLE;
      end
      ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed testbench for lsu_bus_master with a small word memory model
// that answers one cycle after each bus handshake.
module tb_lsu_bus_master;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [3:0]  mem_req_wstrb;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  int checks = 0;
  int errors = 0;

  // Memory model state
  logic [31:0] mem [0:255];
  bit          preloaded = 1'b0;
  logic        model_rsp_valid = 1'b0;
  logic [31:0] model_rdata = 32'b0;
  logic        mute = 1'b0;
  logic        stray_rsp = 1'b0;
  logic [31:0] stray_data = 32'b0;

  // Observed bus beats
  logic [31:0] beat_addr [$];
  logic [31:0] beat_wdata [$];
  logic [3:0]  beat_strb [$];
  logic        beat_wen [$];

  // Per-access results
  logic [31:0] rd;
  logic        er;
  int          lat;
  logic        rdy_at_resp;
  int          base;

  assign mem_rsp_valid = model_rsp_valid | stray_rsp;
  assign mem_rsp_rdata = stray_rsp ? stray_data : model_rdata;

  lsu_bus_master #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wen   (mem_req_wen),
    .mem_req_wstrb (mem_req_wstrb),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata)
  );

  always #5 clk = ~clk;

  // Zero-wait memory: respond the cycle after a handshake, apply strobes.
  always @(posedge clk) begin
    if (!preloaded) begin
      mem[64]   <= 32'h44332211;
      mem[65]   <= 32'h88776655;
      preloaded <= 1'b1;
    end
    model_rsp_valid <= 1'b0;
    if (rst_n && mem_req_valid && mem_req_ready && !mute) begin
      model_rsp_valid <= 1'b1;
      if (mem_req_wen) begin
        for (int b = 0; b < 4; b++)
          if (mem_req_wstrb[b]) mem[mem_req_addr[9:2]][8*b +: 8] <= mem_req_wdata[8*b +: 8];
        model_rdata <= 32'b0;
      end else begin
        model_rdata <= mem[mem_req_addr[9:2]];
      end
    end
  end

  // Beat monitor
  always @(posedge clk) begin
    if (rst_n && mem_req_valid && mem_req_ready) begin
      beat_addr.push_back(mem_req_addr);
      beat_wdata.push_back(mem_req_wdata);
      beat_strb.push_back(mem_req_wstrb);
      beat_wen.push_back(mem_req_wen);
    end
  end

  // Issue one request and wait (bounded) for its response pulse.
  // lat counts cycles from the accept edge to the resp_valid cycle.
  task automatic do_access(input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL resp_timeout: resp_valid=%b after %0d cycles, required 1", resp_valid, lat);
    end
    rd          = resp_rdata;
    er          = resp_err;
    rdy_at_resp = req_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_req_ready: got %b required 1", req_ready);
    end
    checks++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_resp: got v=%b e=%b d=%h required 0/0/0", resp_valid, resp_err, resp_rdata);
    end
    checks++;
    if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0 || mem_req_wen !== 1'b0 ||
        mem_req_wstrb !== 4'h0 || mem_req_wdata !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_mem: got v=%b a=%h w=%b s=%b d=%h required all 0",
                         mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wstrb, mem_req_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_aligned_load();
    base = beat_addr.size();
    do_access(1'b0, F3_W, 32'h100, 32'h0);
    checks++;
    if (rd !== 32'h44332211) begin
      errors++; $display("[TB] FAIL lw_100_data: got %h required 44332211", rd);
    end
    checks++;
    if (lat !== 3) begin
      errors++; $display("[TB] FAIL lw_100_latency: got %0d required 3", lat);
    end
    checks++;
    if (er !== 1'b0) begin
      errors++; $display("[TB] FAIL lw_100_err: got %b required 0", er);
    end
    checks++;
    if (beat_addr.size() - base !== 1 || beat_addr[base] !== 32'h100 ||
        beat_wen[base] !== 1'b0 || beat_strb[base] !== 4'b0000) begin
      errors++; $display("[TB] FAIL lw_100_beat: got n=%0d a=%h w=%b s=%b required 1/00000100/0/0000",
                         beat_addr.size() - base, beat_addr[base], beat_wen[base], beat_strb[base]);
    end
  endtask

  task automatic test_byte_half();
    do_access(1'b0, F3_B, 32'h107, 32'h0);
    checks++;
    if (rd !== 32'hFFFFFF88) begin
      errors++; $display("[TB] FAIL lb_107: got %h required ffffff88", rd);
    end
    do_access(1'b0, F3_BU, 32'h107, 32'h0);
    checks++;
    if (rd !== 32'h00000088) begin
      errors++; $display("[TB] FAIL lbu_107: got %h required 00000088", rd);
    end
    do_access(1'b0, F3_HU, 32'h106, 32'h0);
    checks++;
    if (rd !== 32'h00008877) begin
      errors++; $display("[TB] FAIL lhu_106: got %h required 00008877", rd);
    end
    do_access(1'b0, F3_H, 32'h106, 32'h0);
    checks++;
    if (rd !== 32'hFFFF8877) begin
      errors++; $display("[TB] FAIL lh_106: got %h required ffff8877", rd);
    end
    do_access(1'b0, F3_B, 32'h101, 32'h0);
    checks++;
    if (rd !== 32'h00000022) begin
      errors++; $display("[TB] FAIL lb_101: got %h required 00000022", rd);
    end
  endtask

  task automatic test_split_load();
    base = beat_addr.size();
    do_access(1'b0, F3_W, 32'h102, 32'h0);
    checks++;
    if (rd !== 32'h66554433) begin
      errors++; $display("[TB] FAIL lw_102_data: got %h required 66554433", rd);
    end
    checks++;
    if (lat !== 5) begin
      errors++; $display("[TB] FAIL lw_102_latency: got %0d required 5", lat);
    end
    checks++;
    if (beat_addr.size() - base !== 2 || beat_addr[base] !== 32'h100 || beat_addr[base+1] !== 32'h104) begin
      errors++; $display("[TB] FAIL lw_102_beats: got n=%0d a0=%h a1=%h required 2/00000100/00000104",
                         beat_addr.size() - base, beat_addr[base], beat_addr[base+1]);
    end
  endtask

  task automatic test_split_store();
    base = beat_addr.size();
    do_access(1'b1, F3_H, 32'h103, 32'h0000BEEF);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0 || lat !== 5) begin
      errors++; $display("[TB] FAIL sh_103_resp: got d=%h e=%b lat=%0d required 0/0/5", rd, er, lat);
    end
    checks++;
    if (beat_addr[base] !== 32'h100 || beat_strb[base] !== 4'b1000 ||
        beat_wdata[base] !== 32'hEF000000 || beat_wen[base] !== 1'b1) begin
      errors++; $display("[TB] FAIL sh_103_beat0: got a=%h s=%b d=%h w=%b required 00000100/1000/ef000000/1",
                         beat_addr[base], beat_strb[base], beat_wdata[base], beat_wen[base]);
    end
    checks++;
    if (beat_addr[base+1] !== 32'h104 || beat_strb[base+1] !== 4'b0001 ||
        beat_wdata[base+1] !== 32'h000000BE || beat_wen[base+1] !== 1'b1) begin
      errors++; $display("[TB] FAIL sh_103_beat1: got a=%h s=%b d=%h w=%b required 00000104/0001/000000be/1",
                         beat_addr[base+1], beat_strb[base+1], beat_wdata[base+1], beat_wen[base+1]);
    end
    do_access(1'b0, F3_W, 32'h100, 32'h0);
    checks++;
    if (rd !== 32'hEF332211) begin
      errors++; $display("[TB] FAIL sh_readback_100: got %h required ef332211", rd);
    end
    do_access(1'b0, F3_W, 32'h104, 32'h0);
    checks++;
    if (rd !== 32'h887766BE) begin
      errors++; $display("[TB] FAIL sh_readback_104: got %h required 887766be", rd);
    end
  endtask

  task automatic test_illegal();
    base = beat_addr.size();
    do_access(1'b0, 3'b011, 32'h100, 32'h0);
    checks++;
    if (er !== 1'b1 || lat !== 1 || rd !== 32'h0) begin
      errors++; $display("[TB] FAIL illegal_load: got e=%b lat=%0d d=%h required 1/1/0", er, lat, rd);
    end
    do_access(1'b1, 3'b100, 32'h100, 32'h12345678);
    checks++;
    if (er !== 1'b1 || lat !== 1 || rd !== 32'h0) begin
      errors++; $display("[TB] FAIL illegal_store: got e=%b lat=%0d d=%h required 1/1/0", er, lat, rd);
    end
    checks++;
    if (beat_addr.size() - base !== 0) begin
      errors++; $display("[TB] FAIL illegal_no_bus: got %0d beats required 0", beat_addr.size() - base);
    end
  endtask

  task automatic test_back_to_back();
    do_access(1'b0, F3_W, 32'h104, 32'h0);
    checks++;
    if (rdy_at_resp !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_ready_in_resp: got %b required 0", rdy_at_resp);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_ready_after: got %b required 1", req_ready);
    end
    do_access(1'b0, F3_HU, 32'h100, 32'h0);
    checks++;
    if (rd !== 32'h00002211 || lat !== 3) begin
      errors++; $display("[TB] FAIL b2b_lhu_100: got d=%h lat=%0d required 00002211/3", rd, lat);
    end
  endtask

  task automatic test_stall_reset();
    mute          = 1'b1;
    mem_req_ready = 1'b0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = F3_W;
    req_addr   = 32'h104;
    req_wdata  = 32'h0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h104 ||
          mem_req_wen !== 1'b0 || mem_req_wstrb !== 4'b0000) begin
        errors++; $display("[TB] FAIL stall_stable_%0d: got v=%b a=%h w=%b s=%b required 1/00000104/0/0000",
                           c, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wstrb);
      end
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_in_wait0: got v=%b r=%b required 0/0", mem_req_valid, resp_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || mem_req_valid !== 1'b0 || resp_valid !== 1'b0 ||
        resp_err !== 1'b0 || resp_rdata !== 32'h0 || mem_req_addr !== 32'h0) begin
      errors++; $display("[TB] FAIL midreset_outputs: got rdy=%b mv=%b rv=%b re=%b rd=%h ma=%h required 1/0/0/0/0/0",
                         req_ready, mem_req_valid, resp_valid, resp_err, resp_rdata, mem_req_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mute  = 1'b0;
    @(negedge clk);
    stray_rsp  = 1'b1;
    stray_data = 32'hDEADBEEF;
    @(negedge clk);
    stray_rsp = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL stray_rsp_ignored: got rv=%b rdy=%b mv=%b required 0/1/0",
                         resp_valid, req_ready, mem_req_valid);
    end
    do_access(1'b0, F3_W, 32'h104, 32'h0);
    checks++;
    if (rd !== 32'h887766BE || lat !== 3 || er !== 1'b0) begin
      errors++; $display("[TB] FAIL post_reset_lw: got d=%h lat=%0d e=%b required 887766be/3/0", rd, lat, er);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_write     = 1'b0;
    req_funct3    = 3'b0;
    req_addr      = 32'h0;
    req_wdata     = 32'h0;
    mem_req_ready = 1'b1;
    test_reset();
    test_aligned_load();
    test_byte_half();
    test_split_load();
    test_split_store();
    test_illegal();
    test_back_to_back();
    test_stall_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, required completion before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
